// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// tt_um_jleugeri_ttt: shared stage/phase types for the token processor scheduler
package tt_um_jleugeri_ttt;
  typedef enum logic [2:0] {RESET, INPUT, RECURRENT, UPDATE, OUTPUT} stage_t;
  typedef enum logic {SCAN, CONN} phase_t;
  function automatic stage_t next_stage(stage_t s);
    return s == INPUT ? RECURRENT : s == RECURRENT ? UPDATE : s == UPDATE ? OUTPUT : INPUT;
  endfunction
endpackage

// File: rtl/tt_um_jleugeri_ttt_scheduler_if.sv
// tt_um_jleugeri_ttt_scheduler_if: scheduler bus towards top level, network and processor core
interface tt_um_jleugeri_ttt_scheduler_if
  import tt_um_jleugeri_ttt::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int NUM_CONNECTIONS = 50
);
  localparam int PW = $clog2(NUM_PROCESSORS);
  localparam int CW = $clog2(NUM_CONNECTIONS + 1);
  logic hold;
  logic done;
  stage_t stage;
  logic ext_valid;
  logic ext_ready;
  logic [PW-1:0] proc_id;
  logic proc_update;
  logic [1:0] proc_startstop;
  logic [CW-1:0] conn_first;
  logic [CW-1:0] conn_end;
  logic [CW-1:0] conn_id;
  logic conn_valid;
  logic out_valid;
  logic out_ready;
  logic [1:0] out_startstop;
  modport master (
    input hold, ext_valid, proc_startstop, conn_first, conn_end, out_ready,
    output done, stage, ext_ready, proc_id, proc_update, conn_id, conn_valid, out_valid, out_startstop
  );
  modport slave (
    output hold, ext_valid, proc_startstop, conn_first, conn_end, out_ready,
    input done, stage, ext_ready, proc_id, proc_update, conn_id, conn_valid, out_valid, out_startstop
  );
endinterface

// File: rtl/tt_um_jleugeri_ttt_range_counter.sv
// tt_um_jleugeri_ttt_range_counter: walks an inclusive index range one step at a time
module tt_um_jleugeri_ttt_range_counter #(
  parameter int W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  input  logic [W-1:0] first,
  input  logic [W-1:0] last,
  output logic [W-1:0] value,
  output logic is_last
);
  logic [W-1:0] last_q;
  always_ff @(posedge clk)
    if (!reset) begin
      value <= '0;
      last_q <= '0;
    end else if (load) begin
      value <= first;
      last_q <= last;
    end else if (step) value <= value + 1'b1;
  assign is_last = value == last_q;
endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// tt_um_jleugeri_ttt_scheduler: stage sequencer generating processor/connection addresses and token handshakes
module tt_um_jleugeri_ttt_scheduler
  import tt_um_jleugeri_ttt::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int NUM_CONNECTIONS = 50
) (
  input logic clk,
  input logic reset,
  tt_um_jleugeri_ttt_scheduler_if.master bus
);
  localparam int PW = $clog2(NUM_PROCESSORS);
  localparam int CW = $clog2(NUM_CONNECTIONS + 1);
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PROCESSORS - 1);
  stage_t stage;
  phase_t phase;
  logic done_q, done, busy, scan, conn, upd, out_scan, has_conn, advance, j_last;
  logic [PW-1:0] i;
  logic [NUM_PROCESSORS-1:0][1:0] record;
  logic [CW-1:0] j;
  // RESET reports done as soon as reset is released; other stages latch done_q
  assign done = reset && (done_q || stage == RESET);
  assign busy = reset && !done_q;
  assign scan = busy && stage == RECURRENT && phase == SCAN;
  assign conn = busy && stage == RECURRENT && phase == CONN;
  assign upd = busy && stage == UPDATE;
  assign out_scan = busy && stage == OUTPUT;
  assign has_conn = |record[i] && bus.conn_first < bus.conn_end;
  assign advance = (scan && !has_conn) || (conn && j_last) || upd ||
                   (out_scan && (!(|record[i]) || bus.out_ready));
  tt_um_jleugeri_ttt_range_counter #(.W(CW)) conn_walk (
    .clk(clk),
    .reset(reset),
    .load(scan && has_conn),
    .step(conn && !j_last),
    .first(bus.conn_first),
    .last(bus.conn_end - 1'b1),
    .value(j),
    .is_last(j_last)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      stage <= RESET;
      phase <= SCAN;
      done_q <= 1'b0;
      i <= '0;
      record <= '0;
    end else if (done && !bus.hold) begin
      stage <= next_stage(stage);
      phase <= SCAN;
      done_q <= 1'b0;
      i <= '0;
    end else begin
      if (upd) record[i] <= bus.proc_startstop;
      if (scan && has_conn) phase <= CONN;
      else if (conn && j_last) phase <= SCAN;
      if (busy && stage == INPUT && !bus.ext_valid) done_q <= 1'b1;
      if (advance) begin
        if (i == LAST_P) done_q <= 1'b1;
        else i <= i + 1'b1;
      end
    end
  assign bus.done = done;
  assign bus.stage = stage;
  assign bus.ext_ready = busy && stage == INPUT && bus.ext_valid;
  assign bus.proc_id = i;
  assign bus.proc_update = upd;
  assign bus.conn_id = j;
  assign bus.conn_valid = conn;
  assign bus.out_valid = out_scan && |record[i];
  assign bus.out_startstop = record[i];
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// tb_tt_um_jleugeri_ttt_scheduler: stage-level model of the scheduler checked cycle by cycle
module tb_tt_um_jleugeri_ttt_scheduler;
  import tt_um_jleugeri_ttt::*;
  localparam int N = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  tt_um_jleugeri_ttt_scheduler_if bif ();
  tt_um_jleugeri_ttt_scheduler dut (.clk(clk), .reset(reset), .bus(bif.master));
  logic [1:0] ss_tab [N];
  logic [1:0] rec [N];
  int net_first [N];
  int net_end [N];
  int stall [N];
  int tests = 0, fails = 0;
  int n_acc, n_rec, n_upd, n_out, n;
  bit ab;
  int conns [$];
  // network and core answer combinationally from the presented processor address
  assign bif.proc_startstop = bif.proc_id < N ? ss_tab[bif.proc_id] : 2'b00;
  assign bif.conn_first = bif.proc_id < N ? 6'(net_first[bif.proc_id]) : 6'd0;
  assign bif.conn_end = bif.proc_id < N ? 6'(net_end[bif.proc_id]) : 6'd0;

  task automatic chk(string name, int got, int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // one clock cycle: fl = {ext_ready, conn_valid, proc_update, out_valid}; -1 marks a don't-care field
  task automatic cyc(string tag, stage_t s, logic d, logic [3:0] fl, int pid, int cid, int ss, bit en);
    logic [19:0] obs, ex, m;
    @(negedge clk);
    obs = {bif.stage, bif.done, bif.ext_ready, bif.conn_valid, bif.proc_update, bif.out_valid,
           bif.proc_id, bif.conn_id, bif.out_startstop};
    ex = {s, d, fl, 4'(pid), 6'(cid), 2'(ss)};
    m = {8'hff, {4{pid >= 0}}, {6{cid >= 0}}, {2{ss >= 0}}};
    if (en) begin
      tests++;
      if (((obs ^ ex) & m) !== 20'h0) begin
        fails++;
        $display("FAIL %s @%0t: got %h want %h mask %h", tag, $time, obs, ex, m);
      end
    end
    if (bif.ext_ready === 1'b1) n_acc++;
    if (bif.stage == RECURRENT && bif.done === 1'b0) n_rec++;
    if (bif.conn_valid === 1'b1) conns.push_back(int'(bif.conn_id));
    if (bif.proc_update === 1'b1) n_upd++;
    if (bif.out_valid === 1'b1) n_out++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b0;
    repeat (cycles) cyc("reset", RESET, 1'b0, 4'b0000, 0, 0, -1, 1'b1);
    reset = 1'b1;
    foreach (rec[k]) rec[k] = 2'b00;
    cyc("reset_done", RESET, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
  endtask

  task automatic run_input(int toks, int hold_cycles);
    n_acc = 0;
    bif.ext_valid = 1'b1;
    repeat (toks) cyc("input_tok", INPUT, 1'b0, 4'b1000, -1, -1, -1, 1'b1);
    bif.ext_valid = 1'b0;
    cyc("input_end", INPUT, 1'b0, 4'b0000, -1, -1, -1, 1'b1);
    bif.ext_valid = 1'b1;
    bif.hold = 1'b1;
    repeat (hold_cycles) cyc("input_hold", INPUT, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
    bif.ext_valid = 1'b0;
    bif.hold = 1'b0;
    cyc("input_done", INPUT, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
  endtask

  // visit every processor; emitters with a non-empty fan-out deliver each connection in order
  task automatic run_rec(int abort_cid, output bit aborted, output int work);
    aborted = 1'b0;
    work = 0;
    n_rec = 0;
    conns.delete();
    for (int p = 0; p < N; p++) begin
      cyc("rec_scan", RECURRENT, 1'b0, 4'b0000, p, -1, -1, 1'b1);
      work++;
      if (rec[p] != 2'b00) begin
        for (int c = net_first[p]; c < net_end[p]; c++) begin
          if (c == abort_cid) begin
            reset = 1'b0;
            cyc("rec_abort", RECURRENT, 1'b0, 4'b0000, -1, -1, -1, 1'b0);
            reset = 1'b1;
            foreach (rec[k]) rec[k] = 2'b00;
            aborted = 1'b1;
            return;
          end
          cyc("rec_conn", RECURRENT, 1'b0, 4'b0100, p, c, -1, 1'b1);
          work++;
        end
      end
    end
    cyc("rec_done", RECURRENT, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
  endtask

  task automatic run_upd();
    n_upd = 0;
    for (int k = 0; k < N; k++) begin
      rec[k] = ss_tab[k];
      cyc("upd", UPDATE, 1'b0, 4'b0010, k, -1, -1, 1'b1);
    end
    cyc("upd_done", UPDATE, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
  endtask

  task automatic run_out();
    n_out = 0;
    for (int p = 0; p < N; p++) begin
      if (rec[p] != 2'b00) begin
        bif.out_ready = 1'b0;
        repeat (stall[p]) cyc("out_wait", OUTPUT, 1'b0, 4'b0001, p, -1, int'(rec[p]), 1'b1);
        bif.out_ready = 1'b1;
        cyc("out_take", OUTPUT, 1'b0, 4'b0001, p, -1, int'(rec[p]), 1'b1);
      end else begin
        bif.out_ready = 1'b0;
        cyc("out_skip", OUTPUT, 1'b0, 4'b0000, p, -1, -1, 1'b1);
      end
    end
    bif.out_ready = 1'b0;
    cyc("out_done", OUTPUT, 1'b1, 4'b0000, -1, -1, -1, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ss_tab[k] = 2'b00;
      net_first[k] = 0;
      net_end[k] = 0;
      stall[k] = 0;
    end
    ss_tab[3] = 2'b01;
    ss_tab[7] = 2'b10;
    net_first[3] = 5;
    net_end[3] = 8;
    net_first[7] = 8;
    net_end[7] = 8;
    stall[3] = 2;
    bif.hold = 1'b0;
    bif.ext_valid = 1'b0;
    bif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);
    run_input(4, 0);
    chk("tokens_round1", n_acc, 4);
    run_rec(-1, ab, n);
    chk("rec1_model_cycles", n, 10);
    chk("rec1_dut_cycles", n_rec, 10);
    chk("rec1_conns", conns.size(), 0);
    run_upd();
    chk("upd_pulses", n_upd, 10);
    chk("model_rec3", int'(rec[3]), 1);
    chk("model_rec7", int'(rec[7]), 2);
    run_out();
    chk("out_valid_cycles", n_out, 4);
    run_input(2, 3);
    chk("tokens_round2", n_acc, 2);
    run_rec(-1, ab, n);
    chk("rec2_model_cycles", n, 13);
    chk("rec2_dut_cycles", n_rec, 13);
    chk("rec2_conn_count", conns.size(), 3);
    if (conns.size() == 3) begin
      chk("rec2_conn0", conns[0], 5);
      chk("rec2_conn1", conns[1], 6);
      chk("rec2_conn2", conns[2], 7);
    end
    stall[3] = 0;
    run_upd();
    run_out();
    chk("out_valid_nostall", n_out, 2);
    run_input(0, 0);
    run_rec(6, ab, n);
    chk("abort_reached", int'(ab), 1);
    cyc("abort_reset", RESET, 1'b1, 4'b0000, 0, 0, -1, 1'b1);
    run_input(1, 0);
    run_rec(-1, ab, n);
    chk("rec3_model_cycles", n, 10);
    chk("rec3_dut_cycles", n_rec, 10);
    chk("rec3_conns", conns.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tt_um_jleugeri_ttt_scheduler.md
Name: tt_um_jleugeri_ttt_scheduler

Overview:
- Stage sequencer for the token processor array; sits between the top level and the network/processor core.
- Steps through RESET, INPUT, RECURRENT, UPDATE and OUTPUT.
- Generates the processor and connection addresses for each stage and handshakes external input and output tokens.
- Keeps a per-processor start/stop record so RECURRENT and OUTPUT visit only processors that emitted tokens.

Parameters:
NUM_PROCESSORS, 10, number of processors; PW = $clog2(NUM_PROCESSORS)
NUM_CONNECTIONS, 50, connection memory depth; CW = $clog2(NUM_CONNECTIONS+1)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-low reset
hold  in  1  while high, a finished stage does not advance
done  out  1  current stage has finished its work
stage  out  3  current stage, stage_t
ext_valid  in  1  external token available (INPUT stage)
ext_ready  out  1  external token accepted this cycle
proc_id  out  PW  processor address to core/network
proc_update  out  1  core performs one update step on proc_id
proc_startstop  in  2  core start/stop result for proc_id, same cycle as proc_update
conn_first  in  CW  network: first connection index of proc_id (combinational)
conn_end  in  CW  network: one-past-last connection index of proc_id
conn_id  out  CW  connection being delivered
conn_valid  out  1  conn_id is valid this cycle
out_valid  out  1  output token presented
out_ready  in  1  consumer accepts output token
out_startstop  out  2  start/stop bits of the presented processor (address on proc_id)

Behaviour:
- reset low: stage=RESET, done=0, all handshake/valid outputs 0, proc_id=0, conn_id=0, startstop record cleared.
  - Reset low in any stage aborts it immediately; no partial-stage state survives.
- RESET, first cycle with reset high: done=1.
  - Next cycle → INPUT if hold=0; otherwise stay in RESET with done=1.
- Generic advance rule:
  - When a stage's work completes, done=1 starting the following cycle.
  - Stage changes on the first cycle with done=1 and hold=0.
  - done drops to 0 on entry to the new stage.
- INPUT:
  - ext_ready = ext_valid (accept every cycle a token is offered).
  - Completes on the first cycle with ext_valid=0.
  - Tokens offered while done=1 are not accepted: ext_ready=0.
- RECURRENT: scan processors i=0..NUM_PROCESSORS-1, proc_id=i.
  - SCAN cycle: if record[i]!=0 and conn_first<conn_end, latch j=conn_first and conn_last=conn_end-1, go to CONN. Otherwise go to i+1.
  - CONN cycles: conn_id=j, conn_valid=1, one connection per cycle.
    - On j==conn_last, return to SCAN with i+1; else j+1.
  - Completes after SCAN of the last processor with no connections, or after its last CONN cycle.
  - Cost: one cycle per processor plus one per delivered connection.
  - Wrap: i does not wrap within a stage; reset to 0 on stage entry.
- UPDATE: for k=0..NUM_PROCESSORS-1, one per cycle: proc_id=k, proc_update=1.
  - record[k] <= proc_startstop in the same cycle.
  - Completes after k=NUM_PROCESSORS-1, i.e. NUM_PROCESSORS cycles.
- OUTPUT: scan i=0..NUM_PROCESSORS-1.
  - If record[i]!=0: out_valid=1, proc_id=i, out_startstop=record[i]; hold all three until the cycle out_ready=1, then move to i+1.
  - If record[i]==0: skip, one cycle.
  - Completes after the last processor.
  - After OUTPUT, advance → INPUT. The record is kept until overwritten by the next UPDATE.
- Only one of ext_ready, conn_valid, proc_update, out_valid is ever high in a cycle.
- RECURRENT in the first round after reset sees a cleared record and completes in exactly NUM_PROCESSORS cycles.

Decomposition:
- Package tt_um_jleugeri_ttt holds stage_t (RESET, INPUT, RECURRENT, UPDATE, OUTPUT).
- Add to the same package the sub-phase enum for RECURRENT (SCAN, CONN).
- Sub-module tt_um_jleugeri_ttt_range_counter: load first/last, step, last flag. Used for the connection walk in RECURRENT.
- The processor scan counter is inline.

Test Plan:
1. Reset low 3 cycles, release, hold=0 → stage RESET with done=1 one cycle, then INPUT, done=0; all valids 0 during reset.
2. INPUT with ext_valid high 4 cycles, then low → 4 ext_ready pulses, done=1 next cycle, then RECURRENT. Repeat with hold=1: stage stays INPUT, done=1, until hold drops.
3. UPDATE with proc_startstop=2'b01 at k=3 and 2'b10 at k=7 → 10 proc_update cycles with proc_id 0..9; record[3]=01, record[7]=10.
4. Next RECURRENT, record as in 3; network gives proc 3 [5,8) and proc 7 [8,8) (empty) → conn_id 5,6,7 with conn_valid; no connections for proc 7; 13 cycles total.
5. OUTPUT with out_ready low 2 cycles at proc 3 → out_valid=1, proc_id=3, out_startstop=01 held 3 cycles; then proc 7 with 10; then done=1.
6. Reset low during the RECURRENT CONN phase at conn_id=6 → next cycle stage=RESET, conn_valid=0. Following RECURRENT sees a cleared record: no conn_valid, 10 cycles.
